// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants for the operand-forwarding scoreboard: Tnew/Tuse encodings
// and an index-width helper used to size stage indices.
package fwd_scoreboard_pkg;

    localparam int TNEW_NONE = 0;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LD   = 2;

    localparam int TUSE_BR   = 0;
    localparam int TUSE_ALU  = 1;
    localparam int TUSE_ST   = 2;

    localparam int CNT_W     = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-port priority match over the in-flight entries: youngest matching write wins.
// Purely combinational; reports whether to forward (hit), from where, and whether to stall.
module fwd_src_sel
    import fwd_scoreboard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic [DEPTH-1:0]        ent_vld,
    input  logic [DEPTH*REG_AW-1:0] ent_wa,
    input  logic [DEPTH*TNEW_W-1:0] ent_tnew,
    input  logic [REG_AW-1:0]       src_addr,
    input  logic [TNEW_W-1:0]       src_tuse,
    output logic                    hazard,
    output logic                    hit,
    output logic [IDX_W-1:0]        stage_idx
);

    logic              found;
    logic [TNEW_W-1:0] tnew_sel;

    // Scan oldest to youngest so the youngest match is the last one to land.
    always_comb begin
        found     = 1'b0;
        tnew_sel  = '0;
        stage_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_vld[k] && (ent_wa[k*REG_AW +: REG_AW] == src_addr)) begin
                found     = 1'b1;
                stage_idx = IDX_W'(k);
                tnew_sel  = ent_tnew[k*TNEW_W +: TNEW_W];
            end
        end
    end

    assign hit    = found && (src_addr != '0) && (tnew_sel == '0);
    assign hazard = found && (src_addr != '0) && (tnew_sel > src_tuse);

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and Tuse/Tnew hazard unit; optional FWD_STATS_EN adds stall/forward counters.
// Zero-latency outputs from DEPTH tracked writes; stall freezes F/D and blocks the issuing entry.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 5,
    parameter int DW      = 32,
    parameter int TNEW_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      iss_valid,
    input  logic [REG_AW-1:0]         iss_wa,
    input  logic [TNEW_W-1:0]         iss_tnew,
    input  logic                      flush,
    input  logic [DEPTH*DW-1:0]       stage_data,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*TNEW_W-1:0] src_tuse,
    input  logic [NUM_SRC*DW-1:0]     src_rf_data,
    output logic [NUM_SRC*DW-1:0]     src_data,
    output logic                      stall
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          fwd_cnt
`endif
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DEPTH-1:0]        ent_vld;
    logic [DEPTH*REG_AW-1:0] ent_wa;
    logic [DEPTH*TNEW_W-1:0] ent_tnew;
    logic [NUM_SRC-1:0]      hazard_vec;
    logic [NUM_SRC-1:0]      hit_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_vld  <= '0;
            ent_wa   <= '0;
            ent_tnew <= '0;
        end else if (flush) begin
            ent_vld  <= '0;
        end else begin
            // A stalled instruction stays in D, so E receives a bubble.
            ent_vld[0]              <= iss_valid & ~stall & (iss_wa != '0);
            ent_wa[0 +: REG_AW]     <= iss_wa;
            ent_tnew[0 +: TNEW_W]   <= iss_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                ent_vld[k]                  <= ent_vld[k-1];
                ent_wa[k*REG_AW +: REG_AW]  <= ent_wa[(k-1)*REG_AW +: REG_AW];
                ent_tnew[k*TNEW_W +: TNEW_W] <=
                    (ent_tnew[(k-1)*TNEW_W +: TNEW_W] == '0) ? '0
                    : ent_tnew[(k-1)*TNEW_W +: TNEW_W] - 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
        logic [IDX_W-1:0] stage_idx;

        fwd_src_sel #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .TNEW_W (TNEW_W),
            .IDX_W  (IDX_W)
        ) u_sel (
            .ent_vld   (ent_vld),
            .ent_wa    (ent_wa),
            .ent_tnew  (ent_tnew),
            .src_addr  (src_addr[p*REG_AW +: REG_AW]),
            .src_tuse  (src_tuse[p*TNEW_W +: TNEW_W]),
            .hazard    (hazard_vec[p]),
            .hit       (hit_vec[p]),
            .stage_idx (stage_idx)
        );

        assign src_data[p*DW +: DW] = hit_vec[p] ? stage_data[int'(stage_idx)*DW +: DW]
                                                 : src_rf_data[p*DW +: DW];
    end

    assign stall = |hazard_vec;

`ifdef FWD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if ((|hit_vec) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed checks of fwd_scoreboard against a history-based reference model.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int REG_AW  = 5;
    localparam int DW      = 32;
    localparam int TNEW_W  = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic iss_valid;
    logic [REG_AW-1:0] iss_wa;
    logic [TNEW_W-1:0] iss_tnew;
    logic flush;
    logic [DEPTH-1:0][DW-1:0]       stage_data;
    logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0][TNEW_W-1:0] src_tuse;
    logic [NUM_SRC-1:0][DW-1:0]     src_rf_data;
    logic [NUM_SRC-1:0][DW-1:0]     src_data;
    logic stall;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .DW(DW), .TNEW_W(TNEW_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .iss_valid   (iss_valid),
        .iss_wa      (iss_wa),
        .iss_tnew    (iss_tnew),
        .flush       (flush),
        .stage_data  (stage_data),
        .src_addr    (src_addr),
        .src_tuse    (src_tuse),
        .src_rf_data (src_rf_data),
        .src_data    (src_data),
        .stall       (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    // Reference model: the last DEPTH issue slots, youngest first. An issue's
    // remaining Tnew at stage k is its issued Tnew minus k, floored at zero.
    typedef struct { bit v; bit [REG_AW-1:0] wa; int tnew; } rec_t;
    rec_t hist[$];
    longint exp_sc, exp_fc;

    task automatic model_clear();
        rec_t r;
        r.v = 0; r.wa = 0; r.tnew = 0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(r);
        exp_sc = 0;
        exp_fc = 0;
    endtask

    function automatic void model_eval(output logic [NUM_SRC-1:0][DW-1:0] d,
                                       output bit st, output bit fw);
        st = 0;
        fw = 0;
        for (int p = 0; p < NUM_SRC; p++) begin
            d[p] = src_rf_data[p];
            if (src_addr[p] != 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (hist[k].v && hist[k].wa == src_addr[p]) begin
                        int t;
                        t = hist[k].tnew - k;
                        if (t < 0) t = 0;
                        if (t == 0) begin
                            d[p] = stage_data[k];
                            fw = 1;
                        end else if (t > int'(src_tuse[p])) begin
                            st = 1;
                        end
                        break;
                    end
                end
            end
        end
    endfunction

    // Advance one clock, updating the model with the pre-edge inputs.
    task automatic tick();
        logic [NUM_SRC-1:0][DW-1:0] d;
        bit st, fw;
        rec_t r;
        model_eval(d, st, fw);
        @(posedge clk);
        if (st) exp_sc++;
        if (fw) exp_fc++;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) hist[k].v = 0;
        end else begin
            r.v = iss_valid && !st && (iss_wa != 0);
            r.wa = iss_wa;
            r.tnew = int'(iss_tnew);
            hist.push_front(r);
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_wa = 0; iss_tnew = 0; flush = 0;
        src_addr = '0; src_tuse = '0;
        stage_data[0] = 32'hA000_0000; stage_data[1] = 32'hB111_1111; stage_data[2] = 32'hC222_2222;
        src_rf_data[0] = 32'h1111_1111; src_rf_data[1] = 32'h2222_2222;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    task automatic issue(input int wa, input int tnew);
        idle();
        iss_valid = 1; iss_wa = REG_AW'(wa); iss_tnew = TNEW_W'(tnew);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
        total++;
        if (src_data !== src_rf_data) begin bad++; $display("FAIL reset_data got=%h want=%h", src_data, src_rf_data); end
        src_addr[0] = 5; src_addr[1] = 9;
        #1;
        total++;
        if (src_data !== src_rf_data || stall !== 1'b0) begin
            bad++; $display("FAIL reset_read got=%h/%0b want=%h/0", src_data, stall, src_rf_data);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_load_use();
        drain();
        issue(5, TNEW_LD);
        src_addr[0] = 5; src_tuse[0] = TNEW_W'(TUSE_ALU);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%0b want=1", stall); end
        total++;
        if (src_data[0] !== 32'h1111_1111) begin bad++; $display("FAIL load_use_rf got=%h want=11111111", src_data[0]); end
        tick();
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL load_use_m_stall got=%0b want=0", stall); end
        total++;
        if (src_data[0] !== 32'h1111_1111) begin bad++; $display("FAIL load_use_m_data got=%h want=11111111", src_data[0]); end
        tick();
        @(negedge clk);
        total++;
        if (src_data[0] !== 32'hC222_2222 || stall !== 1'b0) begin
            bad++; $display("FAIL load_use_w got=%h/%0b want=c2222222/0", src_data[0], stall);
        end
        tick();
    endtask

    task automatic test_youngest();
        drain();
        issue(8, TNEW_ALU);
        issue(8, TNEW_NONE);
        src_addr[1] = 8; src_tuse[1] = TNEW_W'(TUSE_ALU);
        @(negedge clk);
        total++;
        if (src_data[1] !== 32'hA000_0000 || stall !== 1'b0) begin
            bad++; $display("FAIL youngest_ready got=%h/%0b want=a0000000/0", src_data[1], stall);
        end
        drain();
        issue(9, TNEW_NONE);
        issue(9, TNEW_ALU);
        src_addr[0] = 9; src_tuse[0] = TNEW_W'(TUSE_BR);
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || src_data[0] !== 32'h1111_1111) begin
            bad++; $display("FAIL youngest_pending got=%h/%0b want=11111111/1", src_data[0], stall);
        end
        tick();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || src_data[0] !== 32'hB111_1111) begin
            bad++; $display("FAIL youngest_m got=%h/%0b want=b1111111/0", src_data[0], stall);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drain();
        issue(0, TNEW_NONE);
        for (int k = 0; k < DEPTH; k++) stage_data[k] = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (src_data !== src_rf_data || stall !== 1'b0) begin
            bad++; $display("FAIL zero_reg got=%h/%0b want=%h/0", src_data, stall, src_rf_data);
        end
        tick();
    endtask

    task automatic test_flush();
        drain();
        issue(3, TNEW_LD);
        src_addr[0] = 3; src_tuse[0] = TNEW_W'(TUSE_BR); flush = 1;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall_driven got=%0b want=1", stall); end
        tick();
        idle();
        src_addr[0] = 3; src_tuse[0] = TNEW_W'(TUSE_BR);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || src_data[0] !== 32'h1111_1111) begin
            bad++; $display("FAIL flush_cleared got=%h/%0b want=11111111/0", src_data[0], stall);
        end
        iss_valid = 1; iss_wa = 3; iss_tnew = TNEW_W'(TNEW_NONE); flush = 1; src_addr = '0;
        tick();
        idle();
        src_addr[0] = 3;
        @(negedge clk);
        total++;
        if (src_data[0] !== 32'h1111_1111) begin
            bad++; $display("FAIL flush_over_issue got=%h want=11111111", src_data[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        issue(4, TNEW_NONE);
        issue(7, TNEW_LD);
        tick();
        src_addr[0] = 4; src_addr[1] = 7; src_tuse = '0;
        @(negedge clk);
        total++;
        if (src_data[0] !== 32'hC222_2222 || stall !== 1'b1) begin
            bad++; $display("FAIL mixed_ports got=%h/%0b want=c2222222/1", src_data[0], stall);
        end
        #1 reset_n = 0;
        model_clear();
        #1;
        total++;
        if (stall !== 1'b0 || src_data !== src_rf_data) begin
            bad++; $display("FAIL async_reset got=%h/%0b want=%h/0", src_data, stall, src_rf_data);
        end
        #1 reset_n = 1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0][DW-1:0] d;
        bit st, fw;
        for (int c = 0; c < 400; c++) begin
            iss_valid = ($urandom_range(3, 0) != 0);
            iss_wa    = REG_AW'($urandom_range(7, 0));
            iss_tnew  = TNEW_W'($urandom_range(TNEW_LD, TNEW_NONE));
            flush     = ($urandom_range(15, 0) == 0);
            for (int k = 0; k < DEPTH; k++) stage_data[k] = $urandom;
            for (int p = 0; p < NUM_SRC; p++) begin
                src_addr[p]    = REG_AW'($urandom_range(7, 0));
                src_tuse[p]    = TNEW_W'($urandom_range(TUSE_ST, TUSE_BR));
                src_rf_data[p] = $urandom;
            end
            @(negedge clk);
            model_eval(d, st, fw);
            total++;
            if (stall !== st) begin bad++; $display("FAIL rand_stall c=%0d got=%0b want=%0b", c, stall, st); end
            for (int p = 0; p < NUM_SRC; p++) begin
                total++;
                if (src_data[p] !== d[p]) begin
                    bad++; $display("FAIL rand_data c=%0d p=%0d got=%h want=%h", c, p, src_data[p], d[p]);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_stats();
`ifdef FWD_STATS_EN
        @(negedge clk);
        total++;
        if (stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, exp_sc); end
        total++;
        if (fwd_cnt !== 32'(exp_fc)) begin bad++; $display("FAIL fwd_cnt got=%0d want=%0d", fwd_cnt, exp_fc); end
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        idle();
        reset_n = 1;
        #1;
        test_reset();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
